// File: rtl/bell_pkg.sv
// Shared types and defaults for the N-player bell-game round controller.
package bell_pkg;

    typedef enum logic [1:0] {StIdle, StArmed, StJudge, StDone} state_e;

    localparam int unsigned NUM_PLAYERS_DEF = 4;
    localparam int unsigned COLOR_W_DEF     = 2;
    localparam int unsigned NUM_W_DEF       = 3;
    localparam int unsigned TARGET_SUM_DEF  = 5;
    localparam int unsigned SCORE_W_DEF     = 10;
    localparam int unsigned POT_W_DEF       = 8;
    localparam int unsigned PENALTY_DEF     = 1;
    localparam int unsigned WIN_MARGIN_DEF  = 50;
    localparam int unsigned TIMEOUT_CYC_DEF = 16;

    // Signed add clamped to the range of a w-bit two's-complement value.
    function automatic int sat_add(input int a, input int b, input int unsigned w);
        int hi;
        int lo;
        int s;
        hi = (1 << (w - 1)) - 1;
        lo = -hi - 1;
        s  = a + b;
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/bell_rr_arbiter.sv
// Round-robin arbiter: the first request at or above ptr (wrapping) is granted.
module bell_rr_arbiter import bell_pkg::*; #(
    parameter int unsigned NUM_PLAYERS = NUM_PLAYERS_DEF,
    localparam int unsigned IDX_W = $clog2(NUM_PLAYERS)
) (
    input  logic [NUM_PLAYERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_PLAYERS-1:0] grant,
    output logic [IDX_W-1:0]       idx
);

    always_comb begin
        logic found;
        int   j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < int'(NUM_PLAYERS); k++) begin
            j = (int'(ptr) + k) % int'(NUM_PLAYERS);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bell_round_ctrl.sv
// Bell-game round controller: latches cards, arbitrates the first press, judges it,
// applies saturating score updates and detects a winner by margin.
module bell_round_ctrl import bell_pkg::*; #(
    parameter int unsigned NUM_PLAYERS = NUM_PLAYERS_DEF,
    parameter int unsigned COLOR_W     = COLOR_W_DEF,
    parameter int unsigned NUM_W       = NUM_W_DEF,
    parameter int unsigned TARGET_SUM  = TARGET_SUM_DEF,
    parameter int unsigned SCORE_W     = SCORE_W_DEF,
    parameter int unsigned POT_W       = POT_W_DEF,
    parameter int unsigned PENALTY     = PENALTY_DEF,
    parameter int unsigned WIN_MARGIN  = WIN_MARGIN_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int unsigned IDX_W = $clog2(NUM_PLAYERS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           round_start,
    input  logic [POT_W-1:0]               pot,
    input  logic [NUM_PLAYERS-1:0]         card_valid,
    input  logic [NUM_PLAYERS*COLOR_W-1:0] card_color,
    input  logic [NUM_PLAYERS*NUM_W-1:0]   card_num,
    input  logic [NUM_PLAYERS-1:0]         press,
    output logic                           busy,
    output logic                           round_done,
    output logic [IDX_W-1:0]               round_winner,
    output logic                           round_right,
    output logic                           round_nopress,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           game_over,
    output logic [IDX_W-1:0]               leader
);

    localparam int unsigned SUM_W      = NUM_W + IDX_W;
    localparam int unsigned NUM_COLORS = 1 << COLOR_W;
    localparam int unsigned TMR_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e                         state_q, state_d;
    logic [POT_W-1:0]               pot_q, pot_d;
    logic [NUM_PLAYERS-1:0]         valid_q, valid_d;
    logic [NUM_PLAYERS*COLOR_W-1:0] color_q, color_d;
    logic [NUM_PLAYERS*NUM_W-1:0]   num_q, num_d;
    logic [TMR_W-1:0]               tmr_q, tmr_d;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic [IDX_W-1:0]               win_q, win_d;
    logic                           right_q, right_d;
    logic                           nopress_q, nopress_d;
    logic signed [SCORE_W-1:0]      score_q [NUM_PLAYERS];
    logic signed [SCORE_W-1:0]      score_d [NUM_PLAYERS];
    logic                           done_q, done_d;
    logic [IDX_W-1:0]               rwin_q, rwin_d;
    logic                           rright_q, rright_d;
    logic                           rnop_q, rnop_d;
    logic                           game_over_q, game_over_d;
    logic [IDX_W-1:0]               leader_q, leader_d;

    logic [NUM_PLAYERS-1:0] grant;
    logic [IDX_W-1:0]       arb_idx;

    bell_rr_arbiter #(
        .NUM_PLAYERS(NUM_PLAYERS)
    ) u_arb (
        .req  (press),
        .ptr  (ptr_q),
        .grant(grant),
        .idx  (arb_idx)
    );

    // Per-colour sums over the latched face-up cards.
    logic [SUM_W-1:0] color_sum [NUM_COLORS];
    logic             right_now;

    always_comb begin
        for (int c = 0; c < int'(NUM_COLORS); c++) begin
            color_sum[c] = '0;
        end
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            if (valid_q[i]) begin
                color_sum[color_q[i*COLOR_W +: COLOR_W]] =
                    color_sum[color_q[i*COLOR_W +: COLOR_W]] + SUM_W'(num_q[i*NUM_W +: NUM_W]);
            end
        end
        right_now = 1'b0;
        for (int c = 0; c < int'(NUM_COLORS); c++) begin
            if (color_sum[c] == SUM_W'(TARGET_SUM)) begin
                right_now = 1'b1;
            end
        end
    end

    // Leader is the lowest-index maximum; the runner-up excludes only that index,
    // so a tie at the top never produces a winner.
    int   best_v;
    int   second_v;
    int   lead_v;
    logic win_now;

    always_comb begin
        best_v = int'(score_q[0]);
        lead_v = 0;
        for (int i = 1; i < int'(NUM_PLAYERS); i++) begin
            if (int'(score_q[i]) > best_v) begin
                best_v = int'(score_q[i]);
                lead_v = i;
            end
        end
        second_v = -(1 << SCORE_W);
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            if (i != lead_v && int'(score_q[i]) > second_v) begin
                second_v = int'(score_q[i]);
            end
        end
        win_now = best_v > second_v + int'(WIN_MARGIN);
    end

    always_comb begin
        state_d     = state_q;
        pot_d       = pot_q;
        valid_d     = valid_q;
        color_d     = color_q;
        num_d       = num_q;
        tmr_d       = tmr_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        right_d     = right_q;
        nopress_d   = nopress_q;
        score_d     = score_q;
        done_d      = 1'b0;
        rwin_d      = rwin_q;
        rright_d    = rright_q;
        rnop_d      = rnop_q;
        game_over_d = game_over_q;
        leader_d    = leader_q;

        unique case (state_q)
            StIdle: begin
                if (round_start && !game_over_q) begin
                    pot_d     = pot;
                    valid_d   = card_valid;
                    color_d   = card_color;
                    num_d     = card_num;
                    tmr_d     = '0;
                    right_d   = 1'b0;
                    nopress_d = 1'b0;
                    state_d   = StArmed;
                end
            end
            StArmed: begin
                if (|grant) begin
                    win_d   = arb_idx;
                    state_d = StJudge;
                end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    nopress_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StJudge: begin
                right_d = right_now;
                ptr_d   = (win_q == IDX_W'(NUM_PLAYERS - 1)) ? '0 : win_q + 1'b1;
                for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                    if (right_now) begin
                        if (IDX_W'(i) == win_q) begin
                            score_d[i] = SCORE_W'(sat_add(int'(score_q[i]), int'(pot_q), SCORE_W));
                        end
                    end else if (IDX_W'(i) == win_q) begin
                        score_d[i] = SCORE_W'(sat_add(int'(score_q[i]),
                                                      -int'(PENALTY * (NUM_PLAYERS - 1)), SCORE_W));
                    end else begin
                        score_d[i] = SCORE_W'(sat_add(int'(score_q[i]), int'(PENALTY), SCORE_W));
                    end
                end
                state_d = StDone;
            end
            StDone: begin
                done_d   = 1'b1;
                rwin_d   = win_q;
                rright_d = right_q;
                rnop_d   = nopress_q;
                if (win_now && !game_over_q) begin
                    game_over_d = 1'b1;
                    leader_d    = IDX_W'(lead_v);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            pot_q       <= '0;
            valid_q     <= '0;
            color_q     <= '0;
            num_q       <= '0;
            tmr_q       <= '0;
            ptr_q       <= '0;
            win_q       <= '0;
            right_q     <= 1'b0;
            nopress_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
                score_q[i] <= '0;
            end
            done_q      <= 1'b0;
            rwin_q      <= '0;
            rright_q    <= 1'b0;
            rnop_q      <= 1'b0;
            game_over_q <= 1'b0;
            leader_q    <= '0;
        end else begin
            state_q     <= state_d;
            pot_q       <= pot_d;
            valid_q     <= valid_d;
            color_q     <= color_d;
            num_q       <= num_d;
            tmr_q       <= tmr_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            right_q     <= right_d;
            nopress_q   <= nopress_d;
            score_q     <= score_d;
            done_q      <= done_d;
            rwin_q      <= rwin_d;
            rright_q    <= rright_d;
            rnop_q      <= rnop_d;
            game_over_q <= game_over_d;
            leader_q    <= leader_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            scores[i*SCORE_W +: SCORE_W] = score_q[i];
        end
    end

    assign busy          = (state_q != StIdle);
    assign round_done    = done_q;
    assign round_winner  = rwin_q;
    assign round_right   = rright_q;
    assign round_nopress = rnop_q;
    assign game_over     = game_over_q;
    assign leader        = leader_q;

endmodule
